// File: rtl/biriscv_trace_arb.sv
// biriscv_trace_arb: dual-retire trace serializer. Two retires per cycle in, one
// entry per cycle out in program order, tagged with a retire sequence number.
// Latency: a pushed entry that becomes the head appears on the outputs on the next cycle.
// Backpressure: the head is held stable while ready_i=0. Retires that find no
// space are dropped, counted and flagged sticky.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   enable_i              capture enable; when low, retires are ignored entirely
//   flush_i               clears FIFO, overflow and drop count; seq keeps running
//   valid0/pc0/opcode0    older retire (pipe0)
//   valid1/pc1/opcode1    younger retire (pipe1)
//   valid_o/pc_o/opcode_o/seq_o  head entry, zeroed when empty; ready_i pops it
//   level_o               occupancy
//   overflow_o            sticky drop flag
//   drop_count_o          saturating drop counter
module biriscv_trace_arb #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              valid0_i,
  input  logic [31:0]       pc0_i,
  input  logic [31:0]       opcode0_i,
  input  logic              valid1_i,
  input  logic [31:0]       pc1_i,
  input  logic [31:0]       opcode1_i,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       opcode_o,
  output logic [31:0]       seq_o,
  input  logic              ready_i,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o,
  output logic [15:0]       drop_count_o
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [31:0]       pc_mem_q  [DEPTH];
  logic [31:0]       op_mem_q  [DEPTH];
  logic [31:0]       seq_mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [LW-1:0]     level_q, level_d, space;
  logic [31:0]       seq_q, seq_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [1:0]        n_push, n_kept, n_drop;
  logic              head_vld, pop;
  logic [31:0]       e0_pc, e0_op, e1_seq;
  logic [16:0]       drop_sum;

  always_comb begin
    n_push = enable_i ? (2'(valid0_i) + 2'(valid1_i)) : 2'd0;

    // Space is taken from the start-of-cycle level; a same-cycle pop does not help.
    space = DEPTH_L - level_q;
    if (space >= LW'(n_push)) begin
      n_kept = n_push;
    end else begin
      n_kept = space[1:0];  // space < n_push <= 2 here, so the slice is exact
    end
    n_drop = n_push - n_kept;

    // First stored entry is pipe0 if present, otherwise a lone pipe1.
    // The second slot is only used when both pipes are valid and both fit.
    e0_pc     = valid0_i ? pc0_i     : pc1_i;
    e0_op     = valid0_i ? opcode0_i : opcode1_i;
    e1_seq    = seq_q + 32'd1;
    wr_ptr_p1 = wr_ptr_q + ADDR_W'(1);

    head_vld = (level_q != '0);
    pop      = head_vld & ready_i;

    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (n_drop != 2'd0);

    level_d  = level_q + LW'(n_kept) - LW'(pop);
    wr_ptr_d = wr_ptr_q + ADDR_W'(n_kept);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);

    // Sequence advances for every enabled retire, kept, dropped or flushed.
    seq_d = seq_q + 32'(n_push);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      seq_q <= seq_d;
      if (flush_i) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end else begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        level_q    <= level_d;
        overflow_q <= overflow_d;
        drop_cnt_q <= drop_cnt_d;
      end
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (n_kept != 2'd0) begin
        pc_mem_q[wr_ptr_q]  <= e0_pc;
        op_mem_q[wr_ptr_q]  <= e0_op;
        seq_mem_q[wr_ptr_q] <= seq_q;
      end
      if (n_kept == 2'd2) begin
        pc_mem_q[wr_ptr_p1]  <= pc1_i;
        op_mem_q[wr_ptr_p1]  <= opcode1_i;
        seq_mem_q[wr_ptr_p1] <= e1_seq;
      end
    end
  end

  assign valid_o      = head_vld;
  assign pc_o         = head_vld ? pc_mem_q[rd_ptr_q]  : 32'd0;
  assign opcode_o     = head_vld ? op_mem_q[rd_ptr_q]  : 32'd0;
  assign seq_o        = head_vld ? seq_mem_q[rd_ptr_q] : 32'd0;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_biriscv_trace_arb.sv
module tb_biriscv_trace_arb;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic        clk = 1'b0;
  logic        rst, enable, flush, v0, v1, rdy;
  logic [31:0] pc0, op0, pc1, op1;
  logic        valid_o, overflow_o;
  logic [31:0] pc_o, opcode_o, seq_o;
  logic [ADDR_W:0] level_o;
  logic [15:0] drop_count_o;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: an ordered queue of {pc, opcode, seq} plus counters.
  logic [95:0] mq[$];
  logic [31:0] m_seq  = 32'd0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_drop = 16'd0;

  biriscv_trace_arb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
    .valid0_i(v0), .pc0_i(pc0), .opcode0_i(op0),
    .valid1_i(v1), .pc1_i(pc1), .opcode1_i(op1),
    .valid_o(valid_o), .pc_o(pc_o), .opcode_o(opcode_o), .seq_o(seq_o),
    .ready_i(rdy), .level_o(level_o), .overflow_o(overflow_o),
    .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    logic [95:0] cand[$];
    logic [31:0] s1;
    int space;
    bit pop;
    pop = (mq.size() > 0) && rdy;
    if (rst) begin
      mq.delete();
      m_seq = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    if (enable) begin
      if (v0) cand.push_back({pc0, op0, m_seq});
      s1 = m_seq + {31'd0, v0};
      if (v1) cand.push_back({pc1, op1, s1});
    end
    if (flush) begin
      mq.delete();
      m_ovf = 0; m_drop = 0;
    end else begin
      space = DEPTH - mq.size();
      if (pop) void'(mq.pop_front());
      foreach (cand[i]) begin
        if (space > 0) begin
          mq.push_back(cand[i]);
          space--;
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
    end
    m_seq = m_seq + 32'(cand.size());
  endtask

  function automatic logic [117:0] model_out();
    logic [95:0] h;
    h = (mq.size() > 0) ? mq[0] : 96'd0;
    return {mq.size() > 0, h, 4'(mq.size()), m_ovf, m_drop};
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; enable = 1;
    v0 = 0; v1 = 0;
    pc0 = 0; op0 = 0; pc1 = 0; op1 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; rdy = 0;
    tick();
    rst = 0;
  endtask

  task automatic push_dual(input logic [31:0] a0, input logic [31:0] a1);
    v0 = 1; pc0 = a0; op0 = a0 ^ 32'h13;
    v1 = 1; pc1 = a1; op1 = a1 ^ 32'h13;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; rdy = 1;
    push_dual(32'hDEAD_0000, 32'hDEAD_0004);
    tick(); tick();
    idle();
    n_total++;
    if ({valid_o, pc_o, opcode_o, seq_o, level_o, overflow_o, drop_count_o} !== 118'd0)
      $display("FAIL reset_state got v=%b pc=%h op=%h seq=%h lvl=%0d ovf=%b drop=%0d expected all zero",
               valid_o, pc_o, opcode_o, seq_o, level_o, overflow_o, drop_count_o);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    rdy = 1;
    v0 = 1; pc0 = 32'h8000_0000; op0 = 32'h0000_0013;
    tick();
    n_total++;
    if ({valid_o, pc_o, seq_o, level_o} !== {1'b1, 32'h8000_0000, 32'd0, 4'd1})
      $display("FAIL single_first got v=%b pc=%h seq=%0d lvl=%0d expected 1 80000000 0 1", valid_o, pc_o, seq_o, level_o);
    else n_pass++;
    pc0 = 32'h8000_0004;
    tick();
    n_total++;
    if ({valid_o, pc_o, seq_o, level_o} !== {1'b1, 32'h8000_0004, 32'd1, 4'd1})
      $display("FAIL single_second got v=%b pc=%h seq=%0d lvl=%0d expected 1 80000004 1 1", valid_o, pc_o, seq_o, level_o);
    else n_pass++;
    idle();
    tick();
    n_total++;
    if ({valid_o, pc_o, opcode_o, seq_o, level_o} !== {1'b0, 96'd0, 4'd0})
      $display("FAIL single_drain got v=%b pc=%h seq=%0d lvl=%0d expected empty zeros", valid_o, pc_o, seq_o, level_o);
    else n_pass++;
  endtask

  task automatic test_dual();
    do_reset();
    rdy = 1;
    v0 = 1; pc0 = 32'h100; op0 = 32'h0000_0013;
    v1 = 1; pc1 = 32'h104; op1 = 32'h0010_0093;
    tick();
    idle();
    n_total++;
    if ({valid_o, pc_o, opcode_o, seq_o, level_o} !== {1'b1, 32'h100, 32'h13, 32'd0, 4'd2})
      $display("FAIL dual_first got pc=%h op=%h seq=%0d lvl=%0d expected 100 00000013 0 2", pc_o, opcode_o, seq_o, level_o);
    else n_pass++;
    tick();
    n_total++;
    if ({valid_o, pc_o, opcode_o, seq_o, level_o} !== {1'b1, 32'h104, 32'h0010_0093, 32'd1, 4'd1})
      $display("FAIL dual_second got pc=%h op=%h seq=%0d lvl=%0d expected 104 00100093 1 1", pc_o, opcode_o, seq_o, level_o);
    else n_pass++;
  endtask

  task automatic test_pipe1_only();
    do_reset();
    rdy = 0;
    v1 = 1; pc1 = 32'h200; op1 = 32'h0000_0073;
    tick();
    idle();
    n_total++;
    if ({valid_o, pc_o, opcode_o, seq_o, level_o} !== {1'b1, 32'h200, 32'h73, 32'd0, 4'd1})
      $display("FAIL pipe1_only got v=%b pc=%h op=%h seq=%0d lvl=%0d expected 1 200 00000073 0 1",
               valid_o, pc_o, opcode_o, seq_o, level_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      push_dual(32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i));
      tick();
    end
    n_total++;
    if ({level_o, overflow_o, drop_count_o} !== {4'd8, 1'b0, 16'd0})
      $display("FAIL ovf_fill got lvl=%0d ovf=%b drop=%0d expected 8 0 0", level_o, overflow_o, drop_count_o);
    else n_pass++;
    push_dual(32'h1020, 32'h1024);
    tick();
    n_total++;
    if ({level_o, overflow_o, drop_count_o} !== {4'd8, 1'b1, 16'd2})
      $display("FAIL ovf_drop got lvl=%0d ovf=%b drop=%0d expected 8 1 2", level_o, overflow_o, drop_count_o);
    else n_pass++;
    // Full with a simultaneous pop: the push is still refused.
    rdy = 1;
    push_dual(32'h2000, 32'h2004);
    tick();
    idle();
    n_total++;
    if ({level_o, drop_count_o, seq_o} !== {4'd7, 16'd4, 32'd1})
      $display("FAIL ovf_full_pop got lvl=%0d drop=%0d seq=%0d expected 7 4 1", level_o, drop_count_o, seq_o);
    else n_pass++;
    for (int k = 1; k < 8; k++) begin
      n_total++;
      if ({valid_o, pc_o, seq_o} !== {1'b1, 32'h1000 + 32'(4 * k), 32'(k)})
        $display("FAIL ovf_drain got v=%b pc=%h seq=%0d expected 1 %h %0d", valid_o, pc_o, seq_o, 32'h1000 + 32'(4 * k), k);
      else n_pass++;
      tick();
    end
    rdy = 0;
    v0 = 1; pc0 = 32'h3000; op0 = 32'h13;
    tick();
    idle();
    n_total++;
    if ({valid_o, pc_o, seq_o, level_o, overflow_o} !== {1'b1, 32'h3000, 32'd12, 4'd1, 1'b1})
      $display("FAIL ovf_next_seq got v=%b pc=%h seq=%0d lvl=%0d ovf=%b expected 1 3000 12 1 1",
               valid_o, pc_o, seq_o, level_o, overflow_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      v0 = 1; pc0 = 32'h400 + 32'(4 * i); op0 = 32'hA0 + 32'(i);
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      rdy = 0;
      tick();
      n_total++;
      if ({valid_o, pc_o, opcode_o, seq_o, level_o} !== {1'b1, 32'h400 + 32'(4 * k), 32'hA0 + 32'(k), 32'(k), 4'(3 - k)})
        $display("FAIL bp_hold got pc=%h op=%h seq=%0d lvl=%0d expected %h %h %0d %0d",
                 pc_o, opcode_o, seq_o, level_o, 32'h400 + 32'(4 * k), 32'hA0 + 32'(k), k, 3 - k);
      else n_pass++;
      rdy = 1;
      tick();
    end
    n_total++;
    if ({valid_o, level_o} !== {1'b0, 4'd0})
      $display("FAIL bp_empty got v=%b lvl=%0d expected 0 0", valid_o, level_o);
    else n_pass++;
  endtask

  task automatic test_flush_enable();
    do_reset();
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      push_dual(32'h500 + 32'(8 * i), 32'h504 + 32'(8 * i));
      tick();
    end
    idle();
    rdy = 1;
    tick(); tick(); tick();
    rdy = 0;
    n_total++;
    if ({level_o, overflow_o, drop_count_o} !== {4'd5, 1'b1, 16'd2})
      $display("FAIL flush_pre got lvl=%0d ovf=%b drop=%0d expected 5 1 2", level_o, overflow_o, drop_count_o);
    else n_pass++;
    flush = 1;
    push_dual(32'h600, 32'h604);
    tick();
    idle();
    n_total++;
    if ({valid_o, level_o, overflow_o, drop_count_o} !== {1'b0, 4'd0, 1'b0, 16'd0})
      $display("FAIL flush_clear got v=%b lvl=%0d ovf=%b drop=%0d expected 0 0 0 0",
               valid_o, level_o, overflow_o, drop_count_o);
    else n_pass++;
    enable = 0;
    push_dual(32'h700, 32'h704);
    tick();
    idle();
    n_total++;
    if ({valid_o, level_o, drop_count_o} !== {1'b0, 4'd0, 16'd0})
      $display("FAIL enable_off got v=%b lvl=%0d drop=%0d expected 0 0 0", valid_o, level_o, drop_count_o);
    else n_pass++;
    v0 = 1; pc0 = 32'h800; op0 = 32'h13;
    tick();
    idle();
    // 10 before flush, +2 in the flush cycle, +0 while disabled.
    n_total++;
    if ({valid_o, pc_o, seq_o, level_o} !== {1'b1, 32'h800, 32'd12, 4'd1})
      $display("FAIL flush_seq got v=%b pc=%h seq=%0d lvl=%0d expected 1 800 12 1", valid_o, pc_o, seq_o, level_o);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    rdy = 0;
    push_dual(32'h900, 32'h904);
    for (int i = 0; i < 32800; i++) tick();
    idle();
    n_total++;
    if ({level_o, overflow_o, drop_count_o} !== {4'd8, 1'b1, 16'hFFFF})
      $display("FAIL drop_saturate got lvl=%0d ovf=%b drop=%h expected 8 1 ffff", level_o, overflow_o, drop_count_o);
    else n_pass++;
    n_total++;
    if (seq_o !== 32'd0)
      $display("FAIL sat_head_seq got %0d expected 0", seq_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [117:0] exp_v;
    logic [117:0] got_v;
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      flush  = ($urandom_range(0, 39) == 0);
      enable = ($urandom_range(0, 7) != 0);
      v0     = $urandom_range(0, 1) != 0;
      v1     = $urandom_range(0, 1) != 0;
      pc0    = $urandom; op0 = $urandom;
      pc1    = $urandom; op1 = $urandom;
      rdy    = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 80));
      tick();
      exp_v = model_out();
      got_v = {valid_o, pc_o, opcode_o, seq_o, level_o, overflow_o, drop_count_o};
      n_total++;
      if (got_v !== exp_v) begin
        if (errs < 10)
          $display("FAIL random_cycle_%0d got %h expected %h", c, got_v, exp_v);
        errs++;
      end else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    rdy = 0;
    test_reset();
    test_single();
    test_dual();
    test_pipe1_only();
    test_overflow();
    test_backpressure();
    test_flush_enable();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/biriscv_trace_arb.md
# biriscv_trace_arb

Dual-retire trace serializer for the biRISC-V debug path. It accepts up to two retired instructions per cycle from the two issue pipes and buffers them in a small FIFO. It emits them one per cycle, in program order, to the single-port instruction trace decoder/logger. Each entry carries a retire sequence number, and overflow is reported, so a lossy trace can be detected off-line.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 4.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- enable_i  in  1  trace capture enable; when low, retires are ignored, with no push, no drop and no sequence advance.
- flush_i  in  1  synchronous clear of FIFO, overflow and drop count.
- valid0_i  in  1  pipe0 retire valid; pipe0 is the older instruction.
- pc0_i  in  32  pipe0 PC.
- opcode0_i  in  32  pipe0 instruction word.
- valid1_i  in  1  pipe1 retire valid; pipe1 is the younger instruction.
- pc1_i  in  32  pipe1 PC.
- opcode1_i  in  32  pipe1 instruction word.
- valid_o  out  1  output entry valid (FIFO non-empty).
- pc_o  out  32  head PC.
- opcode_o  out  32  head opcode.
- seq_o  out  32  head retire sequence number.
- ready_i  in  1  sink accepts head this cycle.
- level_o  out  ADDR_W+1  current occupancy.
- overflow_o  out  1  sticky; set when any retire is dropped.
- drop_count_o  out  16  saturating count of dropped retires.

## Operation
- Each cycle, n_push = valid0_i + valid1_i when enable_i=1, else 0.
- Space is computed at the start of the cycle: space = DEPTH - level. A pop in the same cycle does not free space for a push in that cycle.
- Accept rules:
  - Both valid, space ≥ 2: push pipe0, then pipe1.
  - Both valid, space = 1: push pipe0; drop pipe1.
  - Both valid, space = 0: drop both.
  - Only pipe1 valid: treated as a single push of pipe1.
- Sequence counter seq (32-bit, resets to 0, wraps modulo 2^32) advances by n_push every enabled cycle, whether entries are kept or dropped.
  - A pipe0 entry is tagged with seq.
  - A pipe1 entry is tagged with seq+1 if pipe0 was also valid, else with seq.
  - Dropped retires therefore appear as gaps in seq_o.
- Every dropped retire sets overflow_o and adds 1 to drop_count_o. Two drops in one cycle add 2. drop_count_o saturates at 16'hFFFF.
- Pop: a pop occurs when valid_o && ready_i, and advances the read pointer by 1.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH. level updates by n_kept − pop.
- Output: pc_o, opcode_o and seq_o show the head entry when valid_o=1, and are forced to 0 when valid_o=0.
- Priority: rst_i > flush_i > push/pop.
  - flush_i empties the FIFO and clears overflow_o and drop_count_o.
  - flush_i does not reset seq.
  - Retires presented in the flush cycle are discarded and are not counted as drops. seq still advances for them if enable_i=1.

## Timing
- Reset values: valid_o=0, pc_o=0, opcode_o=0, seq_o=0, level_o=0, overflow_o=0, drop_count_o=0, internal seq=0.
- Latency: a retire pushed in cycle N is visible on the outputs in cycle N+1 if it is the head. In a dual push, pipe1 is visible at N+2 at the earliest.
- Throughput: 1 entry/cycle out; 2 entries/cycle in.
- Backpressure: while valid_o=1 and ready_i=0, pc_o, opcode_o and seq_o hold stable.
- Simultaneous push and pop at level=DEPTH:
  - Pushes are dropped, because space was computed as 0.
  - The pop still occurs, so level becomes DEPTH−1.
- Empty with a push: valid_o rises the next cycle. There is no bypass (valid_o never asserts in the same cycle as the push).
- Reset or flush mid-stream: the next cycle has valid_o=0 and level_o=0. Entries pending in the FIFO are lost without counting as drops.

## Test plan
- Single pipe0 retires: pc 0x8000_0000 and 0x8000_0004 on consecutive cycles with ready_i=1 → output on cycles N+1 and N+2 with seq_o = 0 and 1; level_o returns to 0.
- Dual issue: valid0 = {0x100, 0x00000013} and valid1 = {0x104, 0x00100093} in one cycle → 0x100/seq 0 out at N+1, 0x104/seq 1 out at N+2.
- Pipe1 only: valid1 alone with pc 0x200 → single entry, seq_o=0.
- Overflow (DEPTH=8): ready_i=0; 4 dual-retire cycles fill the FIFO to level 8; then one more dual retire → drop_count_o=2, overflow_o=1, level_o=8. Release ready_i → 8 entries drain with seq 0–7. The next retire is tagged seq 10.
- Backpressure hold: 3 entries queued, ready_i toggles 0/1 → outputs stable during ready_i=0; order and seq are preserved.
- Flush and enable: flush_i at level 5 with overflow set → next cycle level_o=0, overflow_o=0, drop_count_o=0, while seq continues. Retires with enable_i=0 → no push, and seq is unchanged.
